memory_access: RTL

- Pipeline stage directly downstream of the execute stage.
- Captures the ALU result, the store data (rs2) and the control bits, then performs at most one data-memory transaction over a req/ack bus.
- Sign- or zero-extends load data and presents a registered writeback bundle to the writeback stage.
- Stalls upstream while a memory transaction is outstanding.

---
 rtl/memory_access.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/memory_access.sv
// memory_access: MEM stage, one req/ack data-memory transaction per instruction.
// Define MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of issuing them.
module memory_access #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2_value,
    input  logic [2:0]  funct3,
    input  logic        in_MemRead,
    input  logic        in_MemWrite,
    input  logic        in_RegWrite,
    input  logic [4:0]  in_RegDest,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wb_valid,
    output logic        wb_RegWrite,
    output logic [4:0]  wb_RegDest,
    output logic [31:0] wb_data,
    output logic        bus_err,
    output logic        exc_misalign
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [31:0] TLIM = 32'(ACK_TIMEOUT);

    state_t      state;
    state_t      nextState;

    logic [31:0] capAddr;
    logic [31:0] capWdata;
    logic [3:0]  capWstrb;
    logic        capWe;
    logic [2:0]  capFunct3;
    logic [4:0]  capDest;
    logic        capRegWrite;
    logic [31:0] toCnt;

    logic        inAccess;
    logic        isMem;
    logic        sizeB;
    logic        sizeH;
    logic        misalign;
    logic        timeoutHit;
    logic [31:0] stWdata;
    logic [3:0]  stWstrb;
    logic [7:0]  byteLane;
    logic [15:0] halfLane;
    logic [31:0] loadData;

    assign isMem = in_MemRead | in_MemWrite;
    // funct3[1:0] picks the size; 011/110/111 fall through to word
    assign sizeB = (funct3[1:0] == 2'b00);
    assign sizeH = (funct3[1:0] == 2'b01);

`ifdef MISALIGN_TRAP_EN
    assign misalign = isMem &
                      ((sizeH & alu_result[0]) |
                       (!sizeB & !sizeH & (alu_result[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        stWdata = rs2_value;
        stWstrb = 4'b1111;
        unique case (1'b1)
            sizeB: begin
                stWdata = {4{rs2_value[7:0]}};
                stWstrb = 4'b0001 << alu_result[1:0];
            end
            sizeH: begin
                stWdata = {2{rs2_value[15:0]}};
                stWstrb = 4'b0011 << {alu_result[1], 1'b0};
            end
            default: ;
        endcase
    end

    assign byteLane = mem_rdata[{capAddr[1:0], 3'b000} +: 8];
    assign halfLane = capAddr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        loadData = mem_rdata;
        unique case (capFunct3)
            3'b000:  loadData = {{24{byteLane[7]}}, byteLane};
            3'b100:  loadData = {24'd0, byteLane};
            3'b001:  loadData = {{16{halfLane[15]}}, halfLane};
            3'b101:  loadData = {16'd0, halfLane};
            default: loadData = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState  = state;
        timeoutHit = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid && isMem && !misalign) begin
                    nextState = ACCESS;
                end
            end
            ACCESS: begin
                // an ack on the limit cycle still completes normally
                if (mem_ack) begin
                    nextState = IDLE;
                end else if ((TLIM != 32'd0) && (toCnt + 32'd1 == TLIM)) begin
                    timeoutHit = 1'b1;
                    nextState  = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    assign inAccess  = (state == ACCESS);
    assign stall     = inAccess;
    assign mem_req   = inAccess;
    assign mem_we    = inAccess & capWe;
    assign mem_addr  = inAccess ? {capAddr[31:2], 2'b00} : 32'd0;
    assign mem_wdata = inAccess ? capWdata : 32'd0;
    assign mem_wstrb = inAccess ? capWstrb : 4'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            capAddr      <= '0;
            capWdata     <= '0;
            capWstrb     <= '0;
            capWe        <= 1'b0;
            capFunct3    <= '0;
            capDest      <= '0;
            capRegWrite  <= 1'b0;
            toCnt        <= '0;
            wb_valid     <= 1'b0;
            wb_RegWrite  <= 1'b0;
            wb_RegDest   <= '0;
            wb_data      <= '0;
            bus_err      <= 1'b0;
            exc_misalign <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            bus_err      <= 1'b0;
            exc_misalign <= 1'b0;
            unique case (state)
                IDLE: begin
                    toCnt <= '0;
                    if (in_valid) begin
                        if (!isMem || misalign) begin
                            wb_valid     <= 1'b1;
                            wb_RegDest   <= in_RegDest;
                            wb_data      <= alu_result;
                            wb_RegWrite  <= !isMem && in_RegWrite &&
                                            (in_RegDest != 5'd0);
                            exc_misalign <= misalign;
                        end else begin
                            capAddr     <= alu_result;
                            capWdata    <= in_MemWrite ? stWdata : 32'd0;
                            capWstrb    <= in_MemWrite ? stWstrb : 4'd0;
                            capWe       <= in_MemWrite;
                            capFunct3   <= funct3;
                            capDest     <= in_RegDest;
                            capRegWrite <= in_RegWrite;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        toCnt       <= '0;
                        wb_valid    <= 1'b1;
                        wb_RegDest  <= capDest;
                        wb_data     <= capWe ? capAddr : loadData;
                        wb_RegWrite <= !capWe && capRegWrite &&
                                       (capDest != 5'd0);
                    end else if (timeoutHit) begin
                        toCnt       <= '0;
                        wb_valid    <= 1'b1;
                        bus_err     <= 1'b1;
                        wb_RegDest  <= capDest;
                        wb_data     <= capAddr;
                        wb_RegWrite <= 1'b0;
                    end else begin
                        toCnt <= toCnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
